fetch_unit: RTL and testbench

- Instruction-fetch front end. It is the consumer of the execute stage's PCOut/flush redirect and the producer of the PC/instr pair that decode, and later execute, consume.
- Holds the fetch PC and issues word requests to instruction memory over a req/ready + rvalid interface.
- Buffers returned instructions in a small in-order queue and presents them to decode with a valid/stall handshake.
- On a redirect from execute, discards all wrong-path work and restarts fetching at the new PC.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues in-order word requests to imem, buffers responses,
// presents PC/instr to decode, and restarts at redirect_pc. Optional macro: FETCH_REDIRECT_CNT_EN.
module fetch_unit #(
    parameter int          PC_W      = 13,
    parameter int          INSTR_W   = 16,
    parameter int unsigned RESET_PC  = 0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_en,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               stall,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    output logic [15:0]        redirect_cnt
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]   CAP  = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(BUF_DEPTH - 1);

    logic [PC_W-1:0]    fetch_pc;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   discard;
    logic [INSTR_W-1:0] buf_instr [BUF_DEPTH];
    logic [PC_W-1:0]    buf_pc    [BUF_DEPTH];
    logic [PC_W-1:0]    tag_q     [BUF_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   tag_rd;
    logic [PTR_W-1:0]   tag_wr;
    logic               accept;
    logic               resp;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Cap on in-flight plus buffered entries keeps both queues from overflowing.
    assign imem_req  = !rst && !redirect_en && (({1'b0, inflight} + {1'b0, count}) < CAP);
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;
    assign resp      = imem_rvalid && (inflight != '0);
    assign pop       = if_valid && !stall;
    assign push      = resp && (discard == '0) && !redirect_en;

    assign if_valid  = (count != '0) && !redirect_en;
    assign if_instr  = buf_instr[head];
    assign if_pc     = buf_pc[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= PC_W'(RESET_PC);
            inflight <= '0;
            count    <= '0;
            discard  <= '0;
            head     <= '0;
            tail     <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
                tag_q[i]     <= '0;
            end
        end else begin
            // Tag queue tracks every accepted request, including wrong-path ones still owed.
            inflight <= inflight + CNT_W'(accept) - CNT_W'(resp);
            if (resp) begin
                tag_rd <= bump(tag_rd);
            end
            if (accept) begin
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= bump(tag_wr);
            end
            if (redirect_en) begin
                fetch_pc <= redirect_pc;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                discard  <= inflight - CNT_W'(resp);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 1'b1;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    buf_instr[tail] <= imem_rdata;
                    buf_pc[tail]    <= tag_q[tag_rd];
                    tail            <= bump(tail);
                end
                if (pop) begin
                    head <= bump(head);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

`ifdef FETCH_REDIRECT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_cnt <= '0;
        end else if (redirect_en && (redirect_cnt != '1)) begin
            redirect_cnt <= redirect_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, redirects, stall hold, PC wrap and async reset.
// Memory returns {3'b101, addr} one cycle after acceptance unless held.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [12:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_en;
    logic [12:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [12:0] if_pc;
`ifdef FETCH_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic        mem_hold = 1'b0;
    logic [12:0] pend [$];

    fetch_unit #(.PC_W(13), .INSTR_W(16), .RESET_PC(0), .BUF_DEPTH(2)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid),
        .if_instr(if_instr),
        .if_pc(if_pc)
`ifdef FETCH_REDIRECT_CNT_EN
        ,
        .redirect_cnt(redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called between edges; returns 2 time units after the next rising edge.
    task automatic tick();
        #1;
        if (imem_req && imem_ready) pend.push_back(imem_addr);
        @(posedge clk);
        #1;
        if (!mem_hold && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = {3'b101, pend.pop_front()};
        end else begin
            imem_rvalid = 1'b0;
        end
        #1;
    endtask

    task automatic expect_next(input string tag, input logic [12:0] pc, input logic [15:0] instr);
        int unsigned n = 0;
        while (!if_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'b0, if_valid}, 32'd1);
        check({tag, "_pc"}, {19'b0, if_pc}, {19'b0, pc});
        check({tag, "_instr"}, {16'b0, if_instr}, {16'b0, instr});
        tick();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect_en = 1'b0;
        stall       = 1'b0;
        imem_rvalid = 1'b0;
        pend.delete();
        #1;
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_instr", {16'b0, if_instr}, 32'd0);
        check("rst_pc", {19'b0, if_pc}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_REDIRECT_CNT_EN
        check("rst_rcnt", {16'b0, redirect_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_req", {31'b0, imem_req}, 32'd1);
        check("rel_addr", {19'b0, imem_addr}, 32'd0);
    endtask

    // Cycle-by-cycle view after each edge of the first stream (L=1, no stall).
    logic        exp_v    [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [12:0] exp_pc   [6] = '{13'h0, 13'h0, 13'h1, 13'h0, 13'h2, 13'h3};
    logic        exp_req  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [12:0] exp_addr [6] = '{13'h1, 13'h0, 13'h2, 13'h3, 13'h0, 13'h4};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        stall       = 1'b0;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("s%0d_valid", i), {31'b0, if_valid}, {31'b0, exp_v[i]});
            if (exp_v[i]) begin
                check($sformatf("s%0d_pc", i), {19'b0, if_pc}, {19'b0, exp_pc[i]});
                check($sformatf("s%0d_instr", i), {16'b0, if_instr}, {16'b0, 3'b101, exp_pc[i]});
            end
            check($sformatf("s%0d_req", i), {31'b0, imem_req}, {31'b0, exp_req[i]});
            if (exp_req[i]) check($sformatf("s%0d_addr", i), {19'b0, imem_addr}, {19'b0, exp_addr[i]});
        end

        // Redirect coinciding with a response and a would-be pop.
        tick();
        tick();
        check("pre_rdr_pc", {19'b0, if_pc}, 32'h4);
        check("pre_rdr_instr", {16'b0, if_instr}, 32'hA004);
        redirect_en = 1'b1;
        redirect_pc = 13'h0200;
        #1;
        check("rdr_mask_valid", {31'b0, if_valid}, 32'd0);
        check("rdr_no_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect_en = 1'b0;
        #1;
        check("post_rdr_req", {31'b0, imem_req}, 32'd1);
        check("post_rdr_addr", {19'b0, imem_addr}, 32'h200);
        expect_next("rdr_same", 13'h0200, 16'hA200);

        // Two requests stuck in flight, then redirect.
        mem_hold = 1'b1;
        repeat (4) tick();
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("hold_valid", {31'b0, if_valid}, 32'd0);
        redirect_en = 1'b1;
        redirect_pc = 13'h0100;
        mem_hold    = 1'b0;
        tick();
        redirect_en = 1'b0;
        #1;
        check("rdr2_addr", {19'b0, imem_addr}, 32'h100);
        check("rdr2_capped", {31'b0, imem_req}, 32'd0);
        expect_next("rdr_inflight", 13'h0100, 16'hA100);

        // PC wrap.
        redirect_en = 1'b1;
        redirect_pc = 13'h1FFE;
        tick();
        redirect_en = 1'b0;
        expect_next("wrap0", 13'h1FFE, 16'hBFFE);
        expect_next("wrap1", 13'h1FFF, 16'hBFFF);
        expect_next("wrap2", 13'h0000, 16'hA000);

        // Stall with full buffer, plus a spurious response while nothing is in flight.
        stall = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall%0d_req", i), {31'b0, imem_req}, 32'd0);
            check($sformatf("stall%0d_valid", i), {31'b0, if_valid}, 32'd1);
            check($sformatf("stall%0d_pc", i), {19'b0, if_pc}, 32'h1);
            check($sformatf("stall%0d_instr", i), {16'b0, if_instr}, 32'hA001);
            if (i == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 16'hDEAD;
            end
            tick();
        end
        stall = 1'b0;
        expect_next("unstall0", 13'h0001, 16'hA001);
        expect_next("unstall1", 13'h0002, 16'hA002);
        expect_next("unstall2", 13'h0003, 16'hA003);

        // Async reset between edges while output is valid.
        stall = 1'b1;
        tick();
        tick();
        check("pre_rst_valid", {31'b0, if_valid}, 32'd1);
        do_reset();
        expect_next("after_rst", 13'h0000, 16'hA000);

        // Back-to-back redirects: last one wins.
        redirect_en = 1'b1;
        redirect_pc = 13'h0010;
        tick();
        redirect_pc = 13'h0020;
        tick();
        redirect_pc = 13'h0030;
        tick();
        redirect_en = 1'b0;
`ifdef FETCH_REDIRECT_CNT_EN
        check("rcnt3", {16'b0, redirect_cnt}, 32'd3);
`endif
        expect_next("b2b_rdr", 13'h0030, 16'hA030);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
